mm_memory_mp: RTL
=================

# mm_memory_mp

Parametrised multi-port main memory for the memory-to-memory processor, and the successor to the fixed 16-bit, three-source memory. It serves NUM_SRC operand reads, a two-word instruction fetch, and one write port with an optional zero-companion write for branches. Contents are cleared by an internal sweep after reset, and a `ready` flag gates use. All read data is registered with one-cycle latency.

## Interface
- DATA_WIDTH, 16, word width in bits; multiple of 8.
- ADDR_WIDTH, 16, byte-address width.
- DEPTH_WORDS, 1024, number of words; power of two, ≤ 2^(ADDR_WIDTH − log2(DATA_WIDTH/8)).
- NUM_SRC, 3, number of operand read ports; 1 to 4.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- src_addr  in  NUM_SRC*ADDR_WIDTH  operand byte addresses; port i occupies slice i.
- src_data  out  NUM_SRC*DATA_WIDTH  operand read data.
- pc  in  ADDR_WIDTH  fetch byte address.
- step  in  ADDR_WIDTH  byte offset to the second fetch word and to the zero-companion word.
- ir_lo  out  DATA_WIDTH  mem[pc].
- ir_hi  out  DATA_WIDTH  mem[pc+step].
- wr_en  in  1  write wr_data to wr_addr.
- wr_zero  in  1  with wr_en, also write 0 to wr_addr+step.
- wr_addr  in  ADDR_WIDTH  write byte address.
- wr_data  in  DATA_WIDTH  write data.
- ready  out  1  high once the clear sweep is complete.
- fault  out  1  sticky address fault; tied to 0 when bounds checking is compiled out.

## Operation
- **Address translation:** word index = byte address >> log2(DATA_WIDTH/8). Address sums (pc+step, wr_addr+step) are computed modulo 2^ADDR_WIDTH.
- **FSM states:**
  - S_INIT: the clear counter writes 0 to word `cnt`, one word per cycle, for cnt = 0 to DEPTH_WORDS−1. Exit to S_RUN after the last word is written.
  - S_RUN: normal operation. The FSM stays in S_RUN until reset.
- **In S_INIT:**
  - wr_en and wr_zero are ignored.
  - All read outputs hold 0.
  - ready = 0.
- **In S_RUN:**
  - Each edge registers src_data[i] = mem[src_addr[i]], ir_lo = mem[pc], ir_hi = mem[pc+step].
  - Reads are read-first: a read returns the contents before the same edge's write.
- **Writes:**
  - On wr_en, mem[wr_addr] ← wr_data.
  - If wr_zero is also set, mem[wr_addr+step] ← 0 on the same edge.
  - If both writes resolve to the same word (e.g. step = 0), wr_data wins.
  - wr_zero without wr_en has no effect.
- **Simultaneous events:** any number of reads may target the same word, including the write target; each returns the old value.

## Timing
- Reset values: src_data, ir_lo, ir_hi = 0; ready = 0; fault = 0; state = S_INIT; cnt = 0.
- ready rises DEPTH_WORDS cycles after the first edge with rst_n = 1.
- Reset asserted mid-sweep or in S_RUN: the sweep restarts from word 0 on the next rst_n = 1 edge. Contents are fully re-cleared.
- Read latency is 1 cycle. Write-to-read visibility is 1 cycle: a read addressed on the edge after a write sees the new value.
- No backpressure. The only handshake is ready; the client must not issue before ready = 1.

## Configuration
- Macro: `MM_MEM_BOUNDS_CHECK_EN`.
- **Defined:**
  - An access is faulting if its word index ≥ DEPTH_WORDS or its byte-offset LSBs are nonzero.
  - A faulting write (either half) is suppressed for that half only.
  - A faulting read returns 0.
  - fault sets on the edge the faulting access is sampled and stays set until reset.
  - Accesses are checked only in S_RUN.
- **Undefined:**
  - The word index is truncated to log2(DEPTH_WORDS) bits, so accesses wrap.
  - LSBs are ignored.
  - fault is constant 0.

## Structure
- Package `mm_mem_pkg`:
  - state enum {S_INIT, S_RUN}
  - function for BYTE_SHIFT = log2(DATA_WIDTH/8)
  - function for IDX_W = log2(DEPTH_WORDS)
- Sub-module `mm_mem_addr_xlate`:
  - Combinational byte address → word index plus fault bit.
  - Instantiated NUM_SRC+4 times: sources, pc, pc+step, wr_addr, wr_addr+step.
- Top level holds the storage array, the FSM/clear counter, and the output registers.

## Test plan
- Reset, then count cycles: ready rises exactly DEPTH_WORDS cycles after rst_n rises; a read of address 6 returns 0.
- Write 5 to address 0 and 10 to address 2; then pc = 0, step = 2 → one cycle later ir_lo = 5, ir_hi = 10.
- Write 13 to address 4 and 27 to address 6; then src_addr = {6,4,2} → one cycle later src_data = {27,13,10}.
- wr_en = wr_zero = 1, wr_addr = 0, wr_data = 56, step = 2; read addresses 0 and 2 → 56 and 0. Repeat with step = 0 → address 0 holds 56.
- Same edge: write 99 to address 4 while reading address 4 → returns 13; the next read returns 99. Reset asserted mid-sweep → ready stays low for a fresh DEPTH_WORDS cycles.
- Bounds checking:
  - With MM_MEM_BOUNDS_CHECK_EN, write to byte address 2*DEPTH_WORDS → fault = 1 and word 0 is unchanged; read of address 3 → returns 0 and fault stays set.
  - Without the macro, the same write lands in word 0.

Source files
------------

// File: rtl/mm_mem_pkg.sv
// Shared types and sizing helpers for the multi-port main memory.
// Optional bounds checking is selected with MM_MEM_BOUNDS_CHECK_EN.
package mm_mem_pkg;

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // Byte-offset bits dropped when turning a byte address into a word index.
  function automatic int byte_shift(input int data_width);
    return $clog2(data_width / 8);
  endfunction

  function automatic int idx_w(input int depth_words);
    return (depth_words > 1) ? $clog2(depth_words) : 1;
  endfunction

endpackage

// File: rtl/mm_mem_addr_xlate.sv
// Byte address to word index translation, plus out-of-range/misaligned fault.
// Combinational, no backpressure. Fault logic exists only with MM_MEM_BOUNDS_CHECK_EN.
module mm_mem_addr_xlate
  import mm_mem_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 16,
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = idx_w(DEPTH_WORDS)
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [IDX_W-1:0]      idx,
  output logic                  flt
);

  localparam int BS = byte_shift(DATA_WIDTH);

  logic [ADDR_WIDTH-1:0] word;

  assign word = addr >> BS;
  assign idx  = word[IDX_W-1:0];

`ifdef MM_MEM_BOUNDS_CHECK_EN
  localparam logic [ADDR_WIDTH-1:0] LSB_MASK = ADDR_WIDTH'((1 << BS) - 1);

  // Widened compare so a full-address-space depth cannot overflow the bound.
  assign flt = ({1'b0, word} >= (ADDR_WIDTH + 1)'(DEPTH_WORDS)) ||
               ((addr & LSB_MASK) != '0);
`else
  logic unused_bits;

  assign unused_bits = ^{addr, word};
  assign flt         = 1'b0;
`endif

endmodule

// File: rtl/mm_memory_mp.sv
// Multi-port main memory: NUM_SRC operand reads, two-word fetch, one write (+zero companion).
// Reads registered, 1-cycle latency, read-first. No backpressure; clients wait for ready.
module mm_memory_mp
  import mm_mem_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 16,
  parameter int DEPTH_WORDS = 1024,
  parameter int NUM_SRC     = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_SRC*ADDR_WIDTH-1:0] src_addr,
  output logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
  input  logic [ADDR_WIDTH-1:0]         pc,
  input  logic [ADDR_WIDTH-1:0]         step,
  output logic [DATA_WIDTH-1:0]         ir_lo,
  output logic [DATA_WIDTH-1:0]         ir_hi,
  input  logic                          wr_en,
  input  logic                          wr_zero,
  input  logic [ADDR_WIDTH-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  output logic                          ready,
  output logic                          fault
);

  localparam int IDX_W = idx_w(DEPTH_WORDS);
  localparam int NX    = NUM_SRC + 4;
  localparam int P_LO  = NUM_SRC;
  localparam int P_HI  = NUM_SRC + 1;
  localparam int P_WR  = NUM_SRC + 2;
  localparam int P_WZ  = NUM_SRC + 3;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  logic [NX-1:0][ADDR_WIDTH-1:0] xa;
  logic [NX-1:0][IDX_W-1:0]      xi;
  logic [NX-1:0]                 xf;

  state_t          state;
  state_t          state_nxt;
  logic [IDX_W-1:0] cnt;
  logic            clr_en;
  logic            run;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src_addr
    assign xa[g] = src_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
  end

  assign xa[P_LO] = pc;
  assign xa[P_HI] = pc + step;
  assign xa[P_WR] = wr_addr;
  assign xa[P_WZ] = wr_addr + step;

  for (genvar g = 0; g < NX; g++) begin : g_xlate
    mm_mem_addr_xlate #(
      .DATA_WIDTH  (DATA_WIDTH),
      .ADDR_WIDTH  (ADDR_WIDTH),
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IDX_W)
    ) u_xlate (
      .addr (xa[g]),
      .idx  (xi[g]),
      .flt  (xf[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_INIT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    clr_en    = 1'b0;
    run       = 1'b0;
    case (state)
      S_INIT: begin
        clr_en = 1'b1;
        if (cnt == IDX_W'(DEPTH_WORDS - 1)) state_nxt = S_RUN;
      end
      S_RUN: run = 1'b1;
      default: state_nxt = S_INIT;
    endcase
  end

  assign ready = run;

  always_ff @(posedge clk) begin
    if (!rst_n)      cnt <= '0;
    else if (clr_en) cnt <= cnt + 1'b1;
  end

  // Zero-companion is written before data so data wins when both hit one word.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (clr_en) begin
        mem[cnt] <= '0;
      end else if (run && wr_en) begin
        if (wr_zero && !xf[P_WZ]) mem[xi[P_WZ]] <= '0;
        if (!xf[P_WR])            mem[xi[P_WR]] <= wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || !run) begin
      src_data <= '0;
      ir_lo    <= '0;
      ir_hi    <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        src_data[i*DATA_WIDTH +: DATA_WIDTH] <= xf[i] ? '0 : mem[xi[i]];
      end
      ir_lo <= xf[P_LO] ? '0 : mem[xi[P_LO]];
      ir_hi <= xf[P_HI] ? '0 : mem[xi[P_HI]];
    end
  end

`ifdef MM_MEM_BOUNDS_CHECK_EN
  logic any_flt;

  // Reads are sampled every running cycle; write halves only when issued.
  assign any_flt = (|xf[P_HI:0]) || (wr_en && xf[P_WR]) || (wr_en && wr_zero && xf[P_WZ]);

  always_ff @(posedge clk) begin
    if (!rst_n)              fault <= 1'b0;
    else if (run && any_flt) fault <= 1'b1;
  end
`else
  assign fault = 1'b0;
`endif

endmodule
